// File: rtl/plot_point_generator.sv
// Column sweep for the function plotter: drives the evaluator per column, maps y to a row, emits pixels.
// Optional: define PLOT_POINT_GENERATOR_CLAMP_EN to clamp off-screen rows instead of skipping the column.
module plot_point_generator #(
  parameter int INTEGER_PART_WIDTH = 3,
  parameter int FRACTIONAL_PART_WIDTH = 2,
  parameter int SCREEN_WIDTH = 32,
  parameter int SCREEN_HEIGHT = 32,
  localparam int NUMBER_WIDTH =
    INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH,
  localparam int COLUMN_WIDTH = $clog2(SCREEN_WIDTH),
  localparam int ROW_WIDTH = $clog2(SCREEN_HEIGHT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUMBER_WIDTH-1:0] x_start,
  input  logic [NUMBER_WIDTH-1:0] x_step,
  output logic                    busy,
  output logic                    done,
  output logic                    eval_start,
  output logic [NUMBER_WIDTH-1:0] eval_x,
  input  logic                    eval_done,
  input  logic [NUMBER_WIDTH-1:0] eval_y,
  output logic                    pixel_valid,
  input  logic                    pixel_ready,
  output logic [COLUMN_WIDTH-1:0] pixel_x,
  output logic [ROW_WIDTH-1:0]    pixel_y
);

  localparam int CENTER_ROW = SCREEN_HEIGHT / 2;
  localparam int RS_W =
    ((NUMBER_WIDTH > ROW_WIDTH) ? NUMBER_WIDTH : ROW_WIDTH) + 2;

  localparam logic signed [RS_W-1:0] CENTER_S =
    RS_W'(CENTER_ROW);
  localparam logic signed [RS_W-1:0] MAX_ROW_S =
    RS_W'(SCREEN_HEIGHT - 1);
  localparam logic [COLUMN_WIDTH-1:0] LAST_COL =
    COLUMN_WIDTH'(SCREEN_WIDTH - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] EVAL    = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] CONVERT = 3'd3;
  localparam logic [2:0] EMIT    = 3'd4;
  localparam logic [2:0] ADVANCE = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  logic [2:0]              state;
  logic [COLUMN_WIDTH-1:0] column;
  logic [NUMBER_WIDTH-1:0] x_q;
  logic [NUMBER_WIDTH-1:0] step_q;
  logic [NUMBER_WIDTH-1:0] y_q;
  logic [ROW_WIDTH-1:0]    row_q;

  logic signed [RS_W-1:0]  y_ext;
  logic signed [RS_W-1:0]  row_s;
  logic                    row_low;
  logic                    row_high;

  // One raw y LSB is one screen row; screen row grows downward
  assign y_ext = {{(RS_W-NUMBER_WIDTH){y_q[NUMBER_WIDTH-1]}}, y_q};
  assign row_s = CENTER_S - y_ext;
  assign row_low = row_s[RS_W-1];
  assign row_high = row_s > MAX_ROW_S;

  assign busy        = state != IDLE;
  assign done        = state == DONE;
  assign eval_start  = state == EVAL;
  assign pixel_valid = state == EMIT;
  assign eval_x      = x_q;
  assign pixel_x     = column;
  assign pixel_y     = row_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      column <= '0;
      x_q    <= '0;
      step_q <= '0;
      y_q    <= '0;
      row_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_q    <= x_start;
            step_q <= x_step;
            column <= '0;
            state  <= EVAL;
          end
        end
        EVAL: state <= WAIT;
        WAIT: begin
          if (eval_done) begin
            y_q   <= eval_y;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          unique case (1'b1)
            row_low: begin
`ifdef PLOT_POINT_GENERATOR_CLAMP_EN
              row_q <= '0;
              state <= EMIT;
`else
              state <= ADVANCE;
`endif
            end
            row_high: begin
`ifdef PLOT_POINT_GENERATOR_CLAMP_EN
              row_q <= ROW_WIDTH'(SCREEN_HEIGHT - 1);
              state <= EMIT;
`else
              state <= ADVANCE;
`endif
            end
            default: begin
              row_q <= row_s[ROW_WIDTH-1:0];
              state <= EMIT;
            end
          endcase
        end
        EMIT: begin
          if (pixel_ready) state <= ADVANCE;
        end
        ADVANCE: begin
          if (column == LAST_COL) begin
            state <= DONE;
          end else begin
            column <= column + 1'b1;
            x_q    <= x_q + step_q;
            state  <= EVAL;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
